// File: rtl/seq_detector_prog_if.sv
// Stream and configuration bundle for the programmable serial pattern detector.
// The master drives serial data and configuration; the slave (the detector) returns match status.
interface seq_detector_prog_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic [PAT_W-1:0] cfg_mask;
   logic             cfg_overlap;
   logic             count_clr;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             armed;

   modport master (
      output in_valid, in, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, count_clr,
      input  match, match_count, armed
   );

   modport slave (
      input  in_valid, in, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, count_clr,
      output match, match_count, armed
   );
endinterface

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: compares the last PAT_W qualified bits against a
// masked run-time pattern, pulses match one cycle later and keeps a saturating match count.
module seq_detector_prog #(
   parameter int               PAT_W       = 4,
   parameter int               CNT_W       = 8,
   parameter logic [PAT_W-1:0] DEF_PATTERN = 4'b1101,
   parameter bit               DEF_OVERLAP = 1'b1
) (
   input logic               clk,
   input logic               reset,
   seq_detector_prog_if.slave bus
);
   localparam int               FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  hist, hist_nxt, nh;
   logic [PAT_W-1:0]  pattern, mask;
   logic              overlap;
   logic [FILL_W-1:0] fill, fill_nxt, nf;
   logic              qualified, hit, match_r;
   logic [CNT_W-1:0]  count, count_nxt;

   // Candidate history/fill if the current bit is accepted, and whether it completes the pattern.
   always_comb begin
      qualified = bus.in_valid && !bus.cfg_load;
      nh        = {hist[PAT_W-2:0], bus.in};
      nf        = (fill == FULL) ? FULL : fill + 1'b1;
      hit       = qualified && (nf == FULL) && (((nh ^ pattern) & mask) == '0);
   end

   // A configuration load wipes the history; in non-overlap mode a hit forces a fresh refill.
   always_comb begin
      hist_nxt = hist;
      fill_nxt = fill;
      if (bus.cfg_load) begin
         hist_nxt = '0;
         fill_nxt = '0;
      end else if (qualified) begin
         hist_nxt = nh;
         fill_nxt = (hit && !overlap) ? '0 : nf;
      end
   end

   always_comb begin
      count_nxt = count;
      if (bus.count_clr) begin
         count_nxt = '0;
      end else if (hit && (count != '1)) begin
         count_nxt = count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hist    <= '0;
         fill    <= '0;
         pattern <= DEF_PATTERN;
         mask    <= '1;
         overlap <= DEF_OVERLAP;
         match_r <= 1'b0;
         count   <= '0;
      end else begin
         hist    <= hist_nxt;
         fill    <= fill_nxt;
         match_r <= hit;
         count   <= count_nxt;
         if (bus.cfg_load) begin
            pattern <= bus.cfg_pattern;
            mask    <= bus.cfg_mask;
            overlap <= bus.cfg_overlap;
         end
      end
   end

   assign bus.match       = match_r;
   assign bus.match_count = count;
   assign bus.armed       = (fill == FULL);
endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: a queue-based reference model predicts each cycle's
// outputs for an 8-bit-count and a 2-bit-count instance driven with identical stimulus.
module tb_seq_detector_prog;
   localparam int PAT_W = 4;

   logic clk = 1'b0;
   logic reset;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   seq_detector_prog_if #(.PAT_W(PAT_W), .CNT_W(8)) bus_a ();
   seq_detector_prog_if #(.PAT_W(PAT_W), .CNT_W(2)) bus_b ();

   assign bus_b.in_valid    = bus_a.in_valid;
   assign bus_b.in          = bus_a.in;
   assign bus_b.cfg_load    = bus_a.cfg_load;
   assign bus_b.cfg_pattern = bus_a.cfg_pattern;
   assign bus_b.cfg_mask    = bus_a.cfg_mask;
   assign bus_b.cfg_overlap = bus_a.cfg_overlap;
   assign bus_b.count_clr   = bus_a.count_clr;

   seq_detector_prog #(.PAT_W(PAT_W), .CNT_W(8), .DEF_PATTERN(4'b1101), .DEF_OVERLAP(1'b1))
      dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
   seq_detector_prog #(.PAT_W(PAT_W), .CNT_W(2), .DEF_PATTERN(4'b1101), .DEF_OVERLAP(1'b1))
      dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

   typedef struct {
      bit match;
      bit armed;
      int cnt8;
      int cnt2;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model: the received bits as a list, bits-since-restart, and plain integer counts.
   bit         m_bits[$];
   int         m_since;
   logic [3:0] m_pat, m_mask;
   bit         m_ovl;
   int         m_cnt8, m_cnt2;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input bit rst_n, input bit v, input bit b, input bit ld,
                                 input logic [3:0] p, input logic [3:0] mk, input bit ov,
                                 input bit clr);
      bit   hit;
      exp_t e;
      hit               = 1'b0;
      reset             = rst_n;
      bus_a.in_valid    = v;
      bus_a.in          = b;
      bus_a.cfg_load    = ld;
      bus_a.cfg_pattern = p;
      bus_a.cfg_mask    = mk;
      bus_a.cfg_overlap = ov;
      bus_a.count_clr   = clr;
      if (!rst_n) begin
         m_bits.delete();
         m_since = 0;
         m_pat   = 4'b1101;
         m_mask  = 4'b1111;
         m_ovl   = 1'b1;
         m_cnt8  = 0;
         m_cnt2  = 0;
      end else begin
         if (ld) begin
            m_pat  = p;
            m_mask = mk;
            m_ovl  = ov;
            m_bits.delete();
            m_since = 0;
         end else if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            if (m_since < PAT_W) m_since++;
            if (m_since == PAT_W) begin
               hit = 1'b1;
               for (int i = 0; i < PAT_W; i++)
                  if (m_mask[PAT_W-1-i] && (m_bits[i] != m_pat[PAT_W-1-i])) hit = 1'b0;
            end
            if (hit && !m_ovl) m_since = 0;
         end
         if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
         end else if (hit) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
      e.match = hit;
      e.armed = (m_since == PAT_W);
      e.cnt8  = m_cnt8;
      e.cnt2  = m_cnt2;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input bit b);
      apply_stimulus(1'b1, 1'b1, b, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
   endtask

   task automatic idle_cycle();
      apply_stimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
   endtask

   task automatic load_cfg(input logic [3:0] p, input logic [3:0] mk, input bit ov);
      apply_stimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, p, mk, ov, 1'b1);
   endtask

   // Every cycle the driver pushes exactly one prediction; compare it just after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check_output("sb_match_a", 32'(bus_a.match), 32'(mon_e.match));
         check_output("sb_match_b", 32'(bus_b.match), 32'(mon_e.match));
         check_output("sb_armed_a", 32'(bus_a.armed), 32'(mon_e.armed));
         check_output("sb_count_a", 32'(bus_a.match_count), mon_e.cnt8);
         check_output("sb_count_b", 32'(bus_b.match_count), mon_e.cnt2);
      end
   end

   initial begin
      logic [6:0] s1_bits, s1_m, s2_m;
      logic [7:0] s3_bits, s3_m, s6_m;
      int         r;
      s1_bits = 7'b1101101;
      s1_m    = 7'b0001001;
      s2_m    = 7'b0001000;
      s3_bits = 8'b11011001;
      s3_m    = 8'b00010001;
      s6_m    = 8'b00011111;

      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
      check_output("reset_match", 32'(bus_a.match), 0);
      check_output("reset_armed", 32'(bus_a.armed), 0);
      check_output("reset_count", 32'(bus_a.match_count), 0);

      // Overlapping detection of the reset-default pattern.
      for (int i = 6; i >= 0; i--) begin
         send_bit(s1_bits[i]);
         check_output($sformatf("ovl_match_bit%0d", 7 - i), 32'(bus_a.match), 32'(s1_m[i]));
         if (i == 3) check_output("ovl_armed_bit4", 32'(bus_a.armed), 1);
      end
      check_output("ovl_count", 32'(bus_a.match_count), 2);

      load_cfg(4'b1101, 4'b1111, 1'b0);
      for (int i = 6; i >= 0; i--) begin
         send_bit(s1_bits[i]);
         check_output($sformatf("novl_match_bit%0d", 7 - i), 32'(bus_a.match), 32'(s2_m[i]));
         if (i == 3) check_output("novl_armed_bit4", 32'(bus_a.armed), 0);
      end
      check_output("novl_count", 32'(bus_a.match_count), 1);

      load_cfg(4'b1001, 4'b1011, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         send_bit(s3_bits[i]);
         check_output($sformatf("mask_match_bit%0d", 8 - i), 32'(bus_a.match), 32'(s3_m[i]));
      end
      check_output("mask_count", 32'(bus_a.match_count), 2);

      load_cfg(4'b1101, 4'b1111, 1'b1);
      for (int i = 6; i >= 0; i--) begin
         repeat ($urandom_range(1, 3)) idle_cycle();
         send_bit(s1_bits[i]);
         check_output($sformatf("gap_match_bit%0d", 7 - i), 32'(bus_a.match), 32'(s1_m[i]));
      end
      check_output("gap_count", 32'(bus_a.match_count), 2);

      load_cfg(4'b1101, 4'b1111, 1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      send_bit(1'b1);
      check_output("rst_mid_match", 32'(bus_a.match), 0);
      check_output("rst_mid_count", 32'(bus_a.match_count), 0);
      check_output("rst_mid_armed", 32'(bus_a.armed), 0);

      // Saturation of the narrow counter, then a clear that coincides with a hit.
      load_cfg(4'b1111, 4'b1111, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1);
         check_output($sformatf("sat_match_bit%0d", 8 - i), 32'(bus_a.match), 32'(s6_m[i]));
      end
      check_output("sat_count_b", 32'(bus_b.match_count), 3);
      check_output("sat_count_a", 32'(bus_a.match_count), 5);
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
      check_output("clr_hit_match", 32'(bus_b.match), 1);
      check_output("clr_hit_count_b", 32'(bus_b.match_count), 0);
      check_output("clr_hit_count_a", 32'(bus_a.match_count), 0);

      load_cfg(4'b1010, 4'b0000, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         send_bit(1'($urandom_range(0, 1)));
         check_output($sformatf("nomask_match_bit%0d", i), 32'(bus_a.match), (i >= 4) ? 1 : 0);
      end

      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2)
            apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                           4'b0000, 4'b0000, 1'b0, 1'b0);
         else if (r < 4)
            apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                           4'($urandom_range(0, 15)), (r == 2) ? 4'b0000 : 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 1'b0);
         else
            apply_stimulus(1'b1, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 1'b0,
                           4'b0000, 4'b0000, 1'b0, (r < 6));
      end

      idle_cycle();
      idle_cycle();
      check_output("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
